hit_event_scheduler: RTL
========================

// Module: hit_event_scheduler
// PURPOSE
//  Collects single-cycle hit pulses from NUM_REQ collision detectors (bullet/alien
//  checkers). Arbitrates them round-robin and issues one paced alien_hit pulse per
//  accepted hit to the score counter / 7-seg display block. Tracks hits for the
//  current wave and flags wave clear at MAX_HITS.
// PARAMETERS
//  NUM_REQ    4   number of hit requesters (2..8)
//  PULSE_GAP  8   minimum cycles between alien_hit rising edges (>=3)
//  MAX_HITS   15  hits per wave; must not exceed score counter saturation (15)
// PORTS
//  clk_100MHz  in   1            system clock, 100 MHz
//  reset       in   1            asynchronous, active-high
//  enable      in   1            game running; low = no new grants
//  clear_all   in   1            sync new-wave restart, 1-cycle pulse
//  hit_req     in   NUM_REQ      1-cycle hit pulse per requester
//  hit_ack     out  NUM_REQ      1-cycle one-hot, requester's hit was issued
//  alien_hit   out  1            1-cycle pulse to score counter
//  grant_id    out  clog2(NUM_REQ)  index of last issued requester
//  hits_total  out  5            hits issued this wave, 0..MAX_HITS
//  all_cleared out  1            high while in DONE
//  busy        out  1            high in ISSUE or GAP
//  drop_count  out  8            merged/dropped requests (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, pending=0, rr pointer=0, gap counter=0, state IDLE.
//  - All outputs registered. pending[i] set on edge sampling hit_req[i]=1.
//    Set wins over same-cycle clear. A pulse while pending[i]=1 merges (one hit).
//  - FSM IDLE: if enable && |pending -> latch RR winner (first pending at or after ptr),
//    go ISSUE. ISSUE (1 cycle): alien_hit=1, hit_ack[w]=1, grant_id=w,
//    pending[w] cleared, hits_total+1, ptr=(w+1) mod NUM_REQ.
//    Next: DONE if new hits_total==MAX_HITS, else GAP. GAP lasts PULSE_GAP-2 cycles.
//    Then IDLE. Continuous pending gives alien_hit exactly PULSE_GAP cycles apart.
//    DONE: all_cleared=1. hit_req ignored, pending held at 0. Exit only via clear_all.
//  - Latency: hit_req sampled at edge k -> alien_hit high from edge k+1 to k+2.
//    This holds when state is IDLE and enable=1.
//  - enable low: no IDLE->ISSUE. ISSUE/GAP in flight complete. pending retained.
//  - clear_all (priority over all but reset): state IDLE, pending=0, hits_total=0.
//    Also ptr=0, gap counter=0, all_cleared=0. hit_req in that same cycle is discarded.
//  - Async reset mid-ISSUE: alien_hit/hit_ack drop immediately. No partial count.
//  - hits_total never exceeds MAX_HITS. ptr wraps NUM_REQ-1 -> 0.
// CONFIGURATION
//  HIT_DROP_COUNT_EN defined: drop_count increments, saturating at 255.
//    It counts each hit_req[i] arriving while pending[i]=1, or while in DONE.
//    If several merge in one cycle, it adds the popcount. clear_all/reset zero it.
//  Undefined: drop_count tied to 8'd0, no counter logic.
// STRUCTURE
//  space_inv_defs.vh: FSM state encodings (IDLE/ISSUE/GAP/DONE).
//    Also holds default MAX_HITS and PULSE_GAP constants, shared with score_display.
//  Sub-module rr_arbiter (NUM_REQ): pending + ptr in, one-hot grant + index out.
//    Purely combinational; the FSM registers its result.
// TESTING
//  1 IDLE, enable=1, hit_req=0001 one cycle -> alien_hit 1 cycle later.
//    Also hit_ack=0001, grant_id=0, hits_total=1.
//  2 hit_req=1111 one cycle -> 4 pulses 8 cycles apart.
//    Grant order 0,1,2,3; hits_total=4; busy low after last GAP.
//  3 Start ptr=2, hit_req=0101 -> grant order 2 then 0.
//  4 Fifteen spaced requests -> 15th pulse, hits_total=15, all_cleared=1.
//    A 16th request gives no alien_hit and no ack. drop_count=1 with macro.
//  5 hit_req[1] pulsed 3x during GAP -> one pulse for requester 1.
//    drop_count=2 with HIT_DROP_COUNT_EN, 0 without.
//  6 enable=0 with pending=0011 -> no pulse for 50 cycles. enable=1 -> grants 0 then 1.
//    clear_all mid-GAP -> IDLE, hits_total=0, pending=0, no further pulse.

Source files
------------

// File: rtl/hit_event_scheduler_pkg.sv
// hit_event_scheduler_pkg
//   Shared definitions for the hit event scheduler: FSM state encoding,
//   default wave/pacing constants (also used by the score display path),
//   and a small popcount helper for the drop counter.
package hit_event_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  localparam int DEF_MAX_HITS  = 15;
  localparam int DEF_PULSE_GAP = 8;
  localparam int SCORE_SAT     = 15;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/hit_event_scheduler_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: first set bit of pending at or
//   after ptr, wrapping. The scheduler FSM registers the result.
//   pending  in   NUM_REQ        requests waiting for service
//   ptr      in   clog2(NUM_REQ) highest-priority index this cycle
//   gnt      out  NUM_REQ        one-hot winner (zero if nothing pending)
//   gnt_idx  out  clog2(NUM_REQ) winner index
//   gnt_vld  out  1              any request pending
module rr_arbiter
  import hit_event_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         pending,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_vld
);
  localparam int IDW = $clog2(NUM_REQ);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = (int'(ptr) + o) % NUM_REQ;
      if (!gnt_vld && pending[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/hit_event_scheduler.sv
// hit_event_scheduler
//   Latches single-cycle hit pulses from NUM_REQ detectors, serves them
//   round-robin and emits one paced alien_hit pulse per accepted hit
//   (rising edges at least PULSE_GAP cycles apart). Counts hits per wave
//   and parks in DONE at MAX_HITS until clear_all.
// Ports
//   clk_100MHz  in   system clock
//   reset       in   async, active-high
//   enable      in   game running; low blocks new grants
//   clear_all   in   sync new-wave restart
//   hit_req     in   per-requester hit pulses
//   hit_ack     out  one-hot, requester's hit issued (1 cycle)
//   alien_hit   out  pulse to score counter
//   grant_id    out  last issued requester
//   hits_total  out  hits issued this wave
//   all_cleared out  high while in DONE
//   busy        out  high in ISSUE or GAP
//   drop_count  out  merged/dropped requests
// Build option: define HIT_DROP_COUNT_EN to enable the saturating drop
//   counter; otherwise drop_count is tied to zero.
module hit_event_scheduler
  import hit_event_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PULSE_GAP = DEF_PULSE_GAP,
  parameter int MAX_HITS  = DEF_MAX_HITS
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_all,
  input  logic [NUM_REQ-1:0]         hit_req,
  output logic [NUM_REQ-1:0]         hit_ack,
  output logic                       alien_hit,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [4:0]                 hits_total,
  output logic                       all_cleared,
  output logic                       busy,
  output logic [7:0]                 drop_count
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int GW  = $clog2(PULSE_GAP);

  sched_state_t       state;
  logic [NUM_REQ-1:0] pending, arb_gnt, clr_mask;
  logic [IDW-1:0]     ptr, arb_idx;
  logic               arb_vld, issue_go;
  logic [GW-1:0]      gap_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pending (pending),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign issue_go = (state == ST_IDLE) && enable && arb_vld;
  // Winner's pending bit is retired on the grant edge; a same-edge new
  // pulse from that requester re-sets it (set wins).
  assign clr_mask = issue_go ? arb_gnt : '0;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      ptr         <= '0;
      gap_cnt     <= '0;
      hit_ack     <= '0;
      alien_hit   <= 1'b0;
      grant_id    <= '0;
      hits_total  <= '0;
      all_cleared <= 1'b0;
      busy        <= 1'b0;
    end else if (clear_all) begin
      state       <= ST_IDLE;
      pending     <= '0;
      ptr         <= '0;
      gap_cnt     <= '0;
      hit_ack     <= '0;
      alien_hit   <= 1'b0;
      hits_total  <= '0;
      all_cleared <= 1'b0;
      busy        <= 1'b0;
    end else begin
      alien_hit <= 1'b0;
      hit_ack   <= '0;
      pending   <= (state == ST_DONE) ? '0 : ((pending & ~clr_mask) | hit_req);
      case (state)
        ST_IDLE: if (issue_go) begin
          state      <= ST_ISSUE;
          alien_hit  <= 1'b1;
          hit_ack    <= arb_gnt;
          grant_id   <= arb_idx;
          hits_total <= hits_total + 5'd1;
          ptr        <= (arb_idx == IDW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
          busy       <= 1'b1;
        end
        ST_ISSUE: if (hits_total == 5'(MAX_HITS)) begin
          state       <= ST_DONE;
          busy        <= 1'b0;
          all_cleared <= 1'b1;
        end else begin
          // ISSUE(1) + GAP(PULSE_GAP-2) + IDLE(1) = PULSE_GAP between pulses
          state   <= ST_GAP;
          gap_cnt <= GW'(PULSE_GAP-3);
        end
        ST_GAP: if (gap_cnt == '0) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HIT_DROP_COUNT_EN
  logic [NUM_REQ-1:0] merged;
  logic [8:0]         drop_sum;

  // A pulse is lost if its requester is still pending (and not being
  // granted this edge) or if the wave is already complete.
  assign merged   = (state == ST_DONE) ? hit_req : (hit_req & pending & ~clr_mask);
  assign drop_sum = {1'b0, drop_count} + {5'd0, popcount8(8'(merged))};

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)          drop_count <= '0;
    else if (clear_all) drop_count <= '0;
    else                drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule
